subleq_ctrl_seq: RTL

- Instruction sequencer for the SUBLEQ processor. It is the initiator side of the data-register and memory transfer protocol.
- Fetches the three operands A, B, C at PC, reads mem[A] and mem[B], writes mem[B]-mem[A] back to B, then branches to C if the result is <= 0, else advances PC by 3.
- Sits between the top-level run control and the memory port; owns the program counter and all transfer timing.

---
 rtl/subleq_ctrl_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/subleq_ctrl_seq.sv
// SUBLEQ instruction sequencer: owns the PC and drives the REQ/ACK memory handshake.
// Optional macro SUBLEQ_STEP_MODE_EN adds a STEP input and runs one instruction per START/STEP.
module subleq_ctrl_seq #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET_bar,
    input  logic                  START,
`ifdef SUBLEQ_STEP_MODE_EN
    input  logic                  STEP,
`endif
    output logic                  MEM_REQ,
    output logic                  MEM_WE,
    output logic [DATA_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    input  logic                  MEM_ACK,
    output logic                  BUSY,
    output logic                  HALTED,
    output logic [DATA_WIDTH-1:0] PC_OUT
);

    typedef enum logic [3:0] {
        StIdle,
        StFetchA,
        StFetchB,
        StFetchC,
        StReadA,
        StReadB,
        StWriteB,
        StBranch,
        StHalt
    } state_e;

    localparam logic [DATA_WIDTH-1:0] AllOnes = '1;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic [DATA_WIDTH-1:0] va_q, va_d;
    logic [DATA_WIDTH-1:0] vb_q, vb_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;

    logic                  start_evt;
    logic [DATA_WIDTH-1:0] result;
    logic                  result_le_zero;
    logic                  mem_state;
    logic [DATA_WIDTH-1:0] xfer_addr;
    state_e                mem_next;

`ifdef SUBLEQ_STEP_MODE_EN
    assign start_evt = START | STEP;
`else
    assign start_evt = START;
`endif

    assign result         = vb_q - va_q;
    assign result_le_zero = (result == '0) || result[DATA_WIDTH-1];

    // Address and successor for each memory-transfer state.
    always_comb begin
        xfer_addr = pc_q;
        mem_next  = StIdle;
        mem_state = 1'b1;
        unique case (state_q)
            StFetchA: begin
                xfer_addr = pc_q;
                mem_next  = StFetchB;
            end
            StFetchB: begin
                xfer_addr = pc_q + DATA_WIDTH'(1);
                mem_next  = StFetchC;
            end
            StFetchC: begin
                xfer_addr = pc_q + DATA_WIDTH'(2);
                mem_next  = StReadA;
            end
            StReadA: begin
                xfer_addr = a_q;
                mem_next  = StReadB;
            end
            StReadB: begin
                xfer_addr = b_q;
                mem_next  = StWriteB;
            end
            StWriteB: begin
                xfer_addr = b_q;
                mem_next  = StBranch;
            end
            default: mem_state = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        va_d     = va_q;
        vb_d     = vb_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        if (mem_state) begin
            // Each memory state enters with REQ low, which gives the mandatory idle gap.
            if (!req_q) begin
                req_d  = 1'b1;
                addr_d = xfer_addr;
                we_d   = (state_q == StWriteB);
                if (state_q == StWriteB) begin
                    wdata_d = result;
                end
            end else if (MEM_ACK) begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                state_d = mem_next;
                unique case (state_q)
                    StFetchA: a_d  = MEM_RDATA;
                    StFetchB: b_d  = MEM_RDATA;
                    StFetchC: c_d  = MEM_RDATA;
                    StReadA:  va_d = MEM_RDATA;
                    StReadB:  vb_d = MEM_RDATA;
                    default:  ;
                endcase
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_evt) begin
                        state_d = StFetchA;
                    end
                end
                StBranch: begin
                    if (result_le_zero && (c_q == AllOnes)) begin
                        state_d = StHalt;
                        pc_d    = AllOnes;
                    end else begin
                        pc_d = result_le_zero ? c_q : pc_q + DATA_WIDTH'(3);
`ifdef SUBLEQ_STEP_MODE_EN
                        state_d = StIdle;
`else
                        state_d = StFetchA;
`endif
                    end
                end
                StHalt: ;
                default: state_d = StIdle;
            endcase
        end

        busy_d   = !((state_d == StIdle) || (state_d == StHalt));
        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge CLOCK or negedge RESET_bar) begin
        if (!RESET_bar) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            a_q      <= AllOnes;
            b_q      <= AllOnes;
            c_q      <= AllOnes;
            va_q     <= AllOnes;
            vb_q     <= AllOnes;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            va_q     <= va_d;
            vb_q     <= vb_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign MEM_REQ   = req_q;
    assign MEM_WE    = we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign BUSY      = busy_q;
    assign HALTED    = halted_q;
    assign PC_OUT    = pc_q;

endmodule
